// File: rtl/regfile_pkg.sv
// Shared sizing, types and helpers for the decode-stage register file.
// Storage, read ports, bus interface and bench all import this package.
package regfile_pkg;

  localparam int DEF_WIDTH    = 64;
  localparam int DEF_REGS     = 32;
  localparam int REG_ADDR_W   = $clog2(DEF_REGS);
  localparam int DEF_ZERO_REG = DEF_REGS - 1;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;
  typedef logic [DEF_WIDTH-1:0]  word_t;

  function automatic bit is_pow2(input int n);
    return (n >= 2) && ((n & (n - 1)) == 0);
  endfunction

endpackage

// File: rtl/regfile_sync_read_if.sv
// Register file bus: two read address/data ports, one write port and stall.
// master drives addresses and write data; slave (the register file) returns read data.
interface regfile_sync_read_if
  import regfile_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int REGS  = DEF_REGS
);

  logic                    stall;
  logic [$clog2(REGS)-1:0] rd_addr_a;
  logic [$clog2(REGS)-1:0] rd_addr_b;
  logic                    wr_en;
  logic [$clog2(REGS)-1:0] wr_addr;
  logic [WIDTH-1:0]        wr_data;
  logic [WIDTH-1:0]        rd_data_a;
  logic [WIDTH-1:0]        rd_data_b;

  modport master (
    output stall,
    output rd_addr_a,
    output rd_addr_b,
    output wr_en,
    output wr_addr,
    output wr_data,
    input  rd_data_a,
    input  rd_data_b
  );

  modport slave (
    input  stall,
    input  rd_addr_a,
    input  rd_addr_b,
    input  wr_en,
    input  wr_addr,
    input  wr_data,
    output rd_data_a,
    output rd_data_b
  );

endinterface

// File: rtl/regfile_read_port.sv
// One synchronous read port: REGS:1 word select, zero/forward priority and
// a stall-holding output register. Output is a flop only.
module regfile_read_port
  import regfile_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int REGS     = DEF_REGS,
  parameter int ZERO_REG = REGS - 1
) (
  input  logic                             i_clk,
  input  logic                             i_rst_n,
  input  logic                             i_stall,
  input  logic [$clog2(REGS)-1:0]          i_rd_addr,
  input  logic                             i_wr_en,
  input  logic [$clog2(REGS)-1:0]          i_wr_addr,
  input  logic [WIDTH-1:0]                 i_wr_data,
  input  logic [REGS-1:0][WIDTH-1:0]       i_words,
  output logic [WIDTH-1:0]                 o_rd_data
);

  localparam int AW = $clog2(REGS);
  localparam logic [AW-1:0] ZERO_ADDR = AW'(ZERO_REG);

  logic [REGS-1:0]  w_lvl;
  logic [WIDTH-1:0] w_sel;
  logic [WIDTH-1:0] w_next;
  logic [WIDTH-1:0] r_rd_data;

  // Per-bit binary select tree, reduced in place from the LSB address bit up;
  // entry i of each level only reads entries 2i and 2i+1, so nothing is clobbered early.
  always_comb begin
    w_lvl = '0;
    w_sel = '0;
    for (int b = 0; b < WIDTH; b++) begin
      for (int r = 0; r < REGS; r++) begin
        w_lvl[r] = i_words[r][b];
      end
      for (int d = 0; d < AW; d++) begin
        for (int i = 0; i < (REGS >> (d + 1)); i++) begin
          w_lvl[i] = i_rd_addr[d] ? w_lvl[2*i+1] : w_lvl[2*i];
        end
      end
      w_sel[b] = w_lvl[0];
    end
  end

  always_comb begin
    w_next = w_sel;
    if (i_rd_addr == ZERO_ADDR) begin
      w_next = '0;
    end else if (i_wr_en && (i_wr_addr == i_rd_addr)) begin
      w_next = i_wr_data;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_rd_data <= '0;
    end else if (!i_stall) begin
      r_rd_data <= w_next;
    end
  end

  assign o_rd_data = r_rd_data;

endmodule

// File: rtl/regfile_sync_read.sv
// Decode-stage register file: REGS-1 writable words plus a hardwired zero
// register, one write port, two registered read ports with forwarding and stall hold.
module regfile_sync_read
  import regfile_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int REGS     = DEF_REGS,
  parameter int ZERO_REG = REGS - 1
) (
  input  logic              clk,
  input  logic              reset_n,
  regfile_sync_read_if.slave bus
);

  logic [REGS-1:0]            w_wr_onehot;
  logic [REGS-1:0][WIDTH-1:0] w_words;

  always_comb begin
    w_wr_onehot                = '0;
    w_wr_onehot[bus.wr_addr]   = bus.wr_en;
    w_wr_onehot[ZERO_REG]      = 1'b0;
  end

  // The zero register has no flop; its slot in the word bus is a constant.
  for (genvar gi = 0; gi < REGS; gi++) begin : g_store
    if (gi == ZERO_REG) begin : g_zero
      assign w_words[gi] = '0;
    end else begin : g_reg
      logic [WIDTH-1:0] r_word;
      always_ff @(posedge clk) begin
        if (!reset_n) begin
          r_word <= '0;
        end else if (w_wr_onehot[gi]) begin
          r_word <= bus.wr_data;
        end
      end
      assign w_words[gi] = r_word;
    end
  end

  regfile_read_port #(
    .WIDTH    (WIDTH),
    .REGS     (REGS),
    .ZERO_REG (ZERO_REG)
  ) u_port_a (
    .i_clk     (clk),
    .i_rst_n   (reset_n),
    .i_stall   (bus.stall),
    .i_rd_addr (bus.rd_addr_a),
    .i_wr_en   (bus.wr_en),
    .i_wr_addr (bus.wr_addr),
    .i_wr_data (bus.wr_data),
    .i_words   (w_words),
    .o_rd_data (bus.rd_data_a)
  );

  regfile_read_port #(
    .WIDTH    (WIDTH),
    .REGS     (REGS),
    .ZERO_REG (ZERO_REG)
  ) u_port_b (
    .i_clk     (clk),
    .i_rst_n   (reset_n),
    .i_stall   (bus.stall),
    .i_rd_addr (bus.rd_addr_b),
    .i_wr_en   (bus.wr_en),
    .i_wr_addr (bus.wr_addr),
    .i_wr_data (bus.wr_data),
    .i_words   (w_words),
    .o_rd_data (bus.rd_data_b)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      assert (is_pow2(REGS))
        else $error("regfile_sync_read: REGS=%0d is not a power of two", REGS);
    end else begin
      assert ($onehot0(w_wr_onehot))
        else $error("regfile_sync_read: write decode not one-hot");
    end
  end

endmodule

// File: tb/tb_regfile_sync_read.sv
// Directed bench for regfile_sync_read: stimulus pushes hand-computed read
// results into a scoreboard queue, an independent monitor pops and compares.
module tb_regfile_sync_read;
  import regfile_pkg::*;

  logic clk = 1'b0;
  logic reset_n = 1'b0;

  regfile_sync_read_if #(.WIDTH(DEF_WIDTH), .REGS(DEF_REGS)) bus ();

  regfile_sync_read #(.WIDTH(DEF_WIDTH), .REGS(DEF_REGS)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    word_t a;
    word_t b;
    string name;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   tests = 0;
  int   fails = 0;

  localparam word_t ONES = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam word_t DEAD = 64'hDEAD_BEEF_0000_0005;

  task automatic step(input bit rn, input bit st, input reg_addr_t ra, input reg_addr_t rb,
                      input bit we, input reg_addr_t wa, input word_t wd,
                      input word_t ea, input word_t eb, input string nm);
    exp_t e;
    reset_n       = rn;
    bus.stall     = st;
    bus.rd_addr_a = ra;
    bus.rd_addr_b = rb;
    bus.wr_en     = we;
    bus.wr_addr   = wa;
    bus.wr_data   = wd;
    @(posedge clk);
    #1;
    e.a    = ea;
    e.b    = eb;
    e.name = nm;
    sb.push_back(e);
  endtask

  // Monitor: outputs are flops, so they are stable at the falling edge.
  initial begin
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        mon_e = sb.pop_front();
        tests++;
        if (bus.rd_data_a !== mon_e.a) begin
          fails++;
          $display("FAIL %s port A: got %h expected %h", mon_e.name, bus.rd_data_a, mon_e.a);
        end
        tests++;
        if (bus.rd_data_b !== mon_e.b) begin
          fails++;
          $display("FAIL %s port B: got %h expected %h", mon_e.name, bus.rd_data_b, mon_e.b);
        end
      end
    end
  end

  initial begin
    bus.stall = 1'b0; bus.rd_addr_a = '0; bus.rd_addr_b = '0;
    bus.wr_en = 1'b0; bus.wr_addr = '0; bus.wr_data = '0;

    //    rn st  A   B  we  wa  wd          expA        expB
    step(0, 0,  0, 30, 0,  0, 0,          0,          0,          "reset0");
    step(0, 0,  4, 30, 1,  4, 64'h99,     0,          0,          "reset1");
    step(1, 0,  0, 30, 0,  0, 0,          0,          0,          "reset_read");
    step(1, 0,  0, 30, 1,  5, DEAD,       0,          0,          "write_idle");
    step(1, 0,  5,  4, 0,  0, 0,          DEAD,       0,          "write_read");
    step(1, 0,  7,  7, 1,  7, 64'h1234,   64'h1234,   64'h1234,   "fwd");
    step(1, 0,  7,  5, 0,  0, 0,          64'h1234,   DEAD,       "fwd_array");
    step(1, 0,  7,  7, 0,  7, 64'hFFFF,   64'h1234,   64'h1234,   "no_we");
    step(1, 0,  0,  1, 1, 31, ONES,       0,          0,          "zero_write");
    step(1, 0, 31,  7, 0,  0, 0,          0,          64'h1234,   "zero_read");
    step(1, 0, 31, 31, 1, 31, ONES,       0,          0,          "zero_nofwd");
    step(1, 0,  5,  7, 1,  5, 64'hAA,     64'hAA,     64'h1234,   "fwd_aa");
    step(1, 0,  5,  7, 0,  0, 0,          64'hAA,     64'h1234,   "read_aa");
    step(1, 1,  6, 31, 1,  5, 64'hBB,     64'hAA,     64'h1234,   "stall_hold");
    step(1, 0,  5,  6, 0,  0, 0,          64'hBB,     0,          "stall_release");
    step(1, 0,  9,  5, 1,  9, 64'h1,      64'h1,      64'hBB,     "b2b_1");
    step(1, 0,  9,  9, 1,  9, 64'h2,      64'h2,      64'h2,      "b2b_2");
    step(1, 0,  9,  3, 0,  0, 0,          64'h2,      0,          "b2b_last");
    step(1, 0,  3,  9, 1,  3, 64'h77,     64'h77,     64'h2,      "fwd_x3");
    step(0, 1,  3,  5, 1,  3, 64'h55,     0,          0,          "rst_prio");
    step(1, 1,  3,  5, 0,  0, 0,          0,          0,          "rst_stall_hold");
    step(1, 0,  3,  5, 0,  0, 0,          0,          0,          "rst_cleared");
    step(1, 0,  9,  7, 0,  0, 0,          0,          0,          "rst_cleared2");

    @(negedge clk);
    #1;
    if (sb.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL drain: %0d entries left, expected 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached before end of stimulus");
    $fatal(1);
  end

endmodule
